stepper_pulse_gen: RTL and testbench
====================================

// Module: stepper_pulse_gen
// PURPOSE
//  Step/direction pulse generator for one axis of the plotter stepper driver. Consumes the speed/direction
//  values the processor writes to the hardwired motor registers (r11-r14) plus a button/enable qualifier.
//  Produces a clean STEP/DIR pin pair: fixed pulse width, guaranteed DIR setup, period derived from speed.
//  Keeps a signed step position counter for read-back. One instance per axis; output pins go straight to the PMOD.
// PARAMETERS
//  PULSE_W    200  STEP high time in clock cycles (2 us at 100 MHz); >= 1
//  DIR_SETUP  100  cycles DIR must be stable before a STEP rising edge; >= 1
// PORTS
//  clock       in   1   system clock, all state on rising edge
//  reset       in   1   asynchronous, active-high; clears all state
//  en          in   1   stepping enable (button OR processor request)
//  speed       in   32  step period in clock cycles, unsigned; 0 = stop
//  direction   in   1   requested direction, 1 = positive
//  clr_pos     in   1   synchronous clear of pos
//  step_out    out  1   STEP pin, registered
//  dir_out     out  1   DIR pin, registered
//  busy        out  1   1 when FSM not in IDLE
//  pos         out  32  signed step count, two's complement, wraps mod 2^32
// BEHAVIOUR
//  Reset values: state=IDLE, step_out=0, dir_out=0, busy=0, pos=0, counter=0. Reset is honoured in any state, mid-pulse included.
//  go = en && (speed != 0). P = max(speed, 2*PULSE_W). P is latched on HIGH entry; speed changes affect the next period only.
//  FSM (all outputs registered, updated on the transition edge):
//   IDLE:  go && direction==dir_out -> HIGH.
//          go && direction!=dir_out -> SETUP, dir_out<=direction.
//   SETUP: counter loaded DIR_SETUP-1. !en -> IDLE (no pulse, dir_out keeps new value). counter==0 -> HIGH.
//   HIGH:  on entry step_out<=1, counter<=PULSE_W-1, pos<=pos+1 if dir_out else pos-1.
//          counter==0 -> step_out<=0, then:
//            en=1 -> LOW (counter<=P-PULSE_W-1)
//            en=0 -> IDLE
//          A started pulse is never truncated, except by reset.
//   LOW:   !go -> IDLE on the next edge.
//          counter==0 && direction==dir_out -> HIGH.
//          counter==0 && direction!=dir_out -> SETUP, dir_out<=direction.
//  Timing:
//   - Latency: go sampled true at edge k in IDLE (same dir) -> step_out=1 after edge k.
//   - Constant speed, same dir: rising-to-rising exactly P cycles; high exactly PULSE_W cycles.
//   - Direction reversal: the period containing SETUP is P + DIR_SETUP.
//  direction is sampled only in IDLE and at the end of LOW; changes mid-HIGH/SETUP are ignored until then.
//  dir_out never changes while step_out=1.
//  clr_pos: pos<=0 next edge. If it coincides with a HIGH entry, clear wins and that step is not counted.
//  pos wraps: 0x7FFFFFFF+1 -> 0x80000000; 0-1 -> 0xFFFFFFFF. No saturation.
//  busy = (state != IDLE).
// TESTING (bench uses PULSE_W=4, DIR_SETUP=3)
//  1 reset; en=1, speed=20, direction=0 held for 3 steps -> 3 pulses of 4 cycles high, rises 20 cycles apart, dir_out=0, pos=0xFFFFFFFD.
//  2 en=1, speed=3, direction=0 -> clamped period: rises 8 cycles apart, high 4 cycles each.
//  3 stepping at speed=20 dir=0, flip direction to 1 mid-LOW -> dir_out rises at the end of LOW; next STEP rise 3 cycles later (period 23); pos increments thereafter.
//  4 en dropped 2 cycles into HIGH -> step_out stays high 4 cycles total, then IDLE, busy=0, no further pulses.
//  5 reset asserted asynchronously mid-HIGH (between clock edges) -> step_out=0, dir_out=0, pos=0, busy=0 immediately; on release with en=1, stepping restarts.
//  6 clr_pos pulsed on the same edge as a HIGH entry -> pos=0 (step not counted); next step, dir=1 -> pos=1.

Source files
------------

// File: rtl/stepper_pulse_gen.sv
// Step/direction pulse generator for one plotter axis: fixed-width STEP pulses,
// guaranteed DIR setup before each rising STEP edge, and a signed position counter.
module stepper_pulse_gen #(
    parameter int unsigned PULSE_W   = 200,
    parameter int unsigned DIR_SETUP = 100
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    input  logic [31:0] speed,
    input  logic        direction,
    input  logic        clr_pos,
    output logic        step_out,
    output logic        dir_out,
    output logic        busy,
    output logic [31:0] pos
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW
    } state_t;

    localparam logic [31:0] PW_C   = 32'(PULSE_W);
    localparam logic [31:0] MIN_P  = 32'(2 * PULSE_W);
    localparam logic [31:0] PW_M1  = 32'(PULSE_W - 1);
    localparam logic [31:0] DS_M1  = 32'(DIR_SETUP - 1);

    state_t      r_state, w_state_nxt;
    logic [31:0] r_cnt, w_cnt_nxt;
    logic [31:0] r_period, w_period_nxt;
    logic [31:0] r_pos, w_pos_nxt;
    logic        r_step, w_step_nxt;
    logic        r_dir, w_dir_nxt;
    logic        w_go;
    logic        w_enter_high;
    logic [31:0] w_p;

    assign w_go = en && (speed != '0);
    assign w_p  = (speed > MIN_P) ? speed : MIN_P;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_period_nxt = r_period;
        w_pos_nxt    = r_pos;
        w_step_nxt   = r_step;
        w_dir_nxt    = r_dir;
        w_enter_high = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_go) begin
                    if (direction == r_dir) begin
                        w_enter_high = 1'b1;
                    end else begin
                        w_state_nxt = S_SETUP;
                        w_dir_nxt   = direction;
                        w_cnt_nxt   = DS_M1;
                    end
                end
            end
            S_SETUP: begin
                if (!en) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == '0) begin
                    w_enter_high = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 32'd1;
                end
            end
            S_HIGH: begin
                if (r_cnt == '0) begin
                    w_step_nxt = 1'b0;
                    if (en) begin
                        w_state_nxt = S_LOW;
                        w_cnt_nxt   = r_period - PW_C - 32'd1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 32'd1;
                end
            end
            S_LOW: begin
                if (!w_go) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == '0) begin
                    if (direction == r_dir) begin
                        w_enter_high = 1'b1;
                    end else begin
                        w_state_nxt = S_SETUP;
                        w_dir_nxt   = direction;
                        w_cnt_nxt   = DS_M1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 32'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Common HIGH-entry actions; r_dir is already the settled direction here.
        if (w_enter_high) begin
            w_state_nxt  = S_HIGH;
            w_step_nxt   = 1'b1;
            w_cnt_nxt    = PW_M1;
            w_period_nxt = w_p;
            w_pos_nxt    = r_dir ? (r_pos + 32'd1) : (r_pos - 32'd1);
        end

        if (clr_pos) begin
            w_pos_nxt = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_period <= '0;
            r_pos    <= '0;
            r_step   <= 1'b0;
            r_dir    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_period <= w_period_nxt;
            r_pos    <= w_pos_nxt;
            r_step   <= w_step_nxt;
            r_dir    <= w_dir_nxt;
        end
    end

    assign step_out = r_step;
    assign dir_out  = r_dir;
    assign busy     = (r_state != S_IDLE);
    assign pos      = r_pos;

endmodule

// File: tb/tb_stepper_pulse_gen.sv
// Bench for stepper_pulse_gen: deadline-based reference model compared every cycle,
// plus directed scenarios with hand-computed pulse timing and position values.
module tb_stepper_pulse_gen;

    localparam int unsigned PW = 4;
    localparam int unsigned DS = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        en;
    logic [31:0] speed;
    logic        direction;
    logic        clr_pos;
    logic        step_out;
    logic        dir_out;
    logic        busy;
    logic [31:0] pos;

    stepper_pulse_gen #(
        .PULSE_W  (PW),
        .DIR_SETUP(DS)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .en       (en),
        .speed    (speed),
        .direction(direction),
        .clr_pos  (clr_pos),
        .step_out (step_out),
        .dir_out  (dir_out),
        .busy     (busy),
        .pos      (pos)
    );

    always #5 clock = ~clock;

    // Reference model: tracks absolute edge deadlines for pulse end, next rise and setup end.
    int unsigned m_edge      = 0;
    bit          m_step      = 1'b0;
    bit          m_dir       = 1'b0;
    bit          m_busy      = 1'b0;
    bit          m_setup     = 1'b0;
    logic [31:0] m_pos       = '0;
    logic [31:0] m_P         = '0;
    int unsigned m_fall      = 0;
    int unsigned m_rise_edge = 0;
    int unsigned m_next_rise = 0;
    int unsigned m_setup_end = 0;

    task automatic m_rise(input int unsigned e);
        m_step      = 1'b1;
        m_busy      = 1'b1;
        m_rise_edge = e;
        m_fall      = e + PW;
        m_P         = (speed > 32'(2 * PW)) ? speed : 32'(2 * PW);
        m_pos       = m_dir ? m_pos + 32'd1 : m_pos - 32'd1;
    endtask

    task automatic m_start_or_setup(input int unsigned e);
        if (direction == m_dir) begin
            m_rise(e);
        end else begin
            m_dir       = direction;
            m_busy      = 1'b1;
            m_setup     = 1'b1;
            m_setup_end = e + DS;
        end
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_step  = 1'b0;
            m_dir   = 1'b0;
            m_busy  = 1'b0;
            m_setup = 1'b0;
            m_pos   = '0;
        end else begin
            m_edge++;
            if (m_step) begin
                if (m_edge == m_fall) begin
                    m_step = 1'b0;
                    if (en) m_next_rise = m_rise_edge + m_P;
                    else    m_busy = 1'b0;
                end
            end else if (m_setup) begin
                if (!en) begin
                    m_setup = 1'b0;
                    m_busy  = 1'b0;
                end else if (m_edge == m_setup_end) begin
                    m_setup = 1'b0;
                    m_rise(m_edge);
                end
            end else if (m_busy) begin
                if (!(en && speed != 0)) m_busy = 1'b0;
                else if (m_edge == m_next_rise) m_start_or_setup(m_edge);
            end else if (en && speed != 0) begin
                m_start_or_setup(m_edge);
            end
            if (clr_pos) m_pos = '0;
        end
    end

    int checks   = 0;
    int failures = 0;
    int ncyc     = 0;
    bit prev_step = 1'b0;
    bit prev_dir  = 1'b0;
    int last_rise = 0;
    int dir_rise_at = -1;
    int rises[$];
    int widths[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        ncyc++;
        if (step_out && !prev_step) begin
            rises.push_back(ncyc);
            last_rise = ncyc;
        end
        if (!step_out && prev_step) widths.push_back(ncyc - last_rise);
        if (dir_out && !prev_dir) dir_rise_at = ncyc;
        prev_step = step_out;
        prev_dir  = dir_out;
        check("model_step_out", {31'd0, step_out}, {31'd0, m_step});
        check("model_dir_out",  {31'd0, dir_out},  {31'd0, m_dir});
        check("model_busy",     {31'd0, busy},     {31'd0, m_busy});
        check("model_pos",      pos,               m_pos);
    endtask

    task automatic clear_log();
        rises.delete();
        widths.delete();
        dir_rise_at = -1;
    endtask

    task automatic check_widths(input string name);
        foreach (widths[i]) check(name, 32'(widths[i]), 32'(PW));
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; speed = '0; direction = 1'b0; clr_pos = 1'b0;
        repeat (3) tick();
        check("reset_step_out", {31'd0, step_out}, 32'd0);
        check("reset_dir_out",  {31'd0, dir_out},  32'd0);
        check("reset_busy",     {31'd0, busy},     32'd0);
        check("reset_pos",      pos,               32'd0);

        // 1: three negative steps at speed 20
        clear_log();
        reset = 1'b0; en = 1'b1; speed = 32'd20; direction = 1'b0;
        repeat (42) tick();
        en = 1'b0;
        repeat (10) tick();
        check("t1_rise_count", 32'(rises.size()), 32'd3);
        if (rises.size() == 3) begin
            check("t1_period_a", 32'(rises[1] - rises[0]), 32'd20);
            check("t1_period_b", 32'(rises[2] - rises[1]), 32'd20);
        end
        check("t1_width_count", 32'(widths.size()), 32'd3);
        check_widths("t1_width");
        check("t1_pos", pos, 32'hFFFF_FFFD);
        check("t1_dir_out", {31'd0, dir_out}, 32'd0);
        check("t1_busy", {31'd0, busy}, 32'd0);

        // 2: speed below 2*PULSE_W is clamped to period 8
        clear_log();
        en = 1'b1; speed = 32'd3;
        repeat (18) tick();
        en = 1'b0;
        repeat (8) tick();
        check("t2_rise_count", 32'(rises.size()), 32'd3);
        if (rises.size() == 3) begin
            check("t2_period_a", 32'(rises[1] - rises[0]), 32'd8);
            check("t2_period_b", 32'(rises[2] - rises[1]), 32'd8);
        end
        check_widths("t2_width");
        check("t2_pos", pos, 32'hFFFF_FFFA);

        // 3: reversal mid-LOW stretches that period by DIR_SETUP
        clear_log();
        en = 1'b1; speed = 32'd20; direction = 1'b0;
        repeat (11) tick();
        direction = 1'b1;
        repeat (35) tick();
        en = 1'b0;
        repeat (8) tick();
        check("t3_rise_count", 32'(rises.size()), 32'd3);
        if (rises.size() == 3) begin
            check("t3_period_rev", 32'(rises[1] - rises[0]), 32'd23);
            check("t3_period_fwd", 32'(rises[2] - rises[1]), 32'd20);
            check("t3_dir_setup", 32'(rises[1] - dir_rise_at), 32'(DS));
        end
        check_widths("t3_width");
        check("t3_pos", pos, 32'hFFFF_FFFB);

        // 4: en dropped mid-pulse does not truncate it
        clear_log();
        en = 1'b1; speed = 32'd20; direction = 1'b1;
        repeat (2) tick();
        en = 1'b0;
        repeat (10) tick();
        check("t4_rise_count", 32'(rises.size()), 32'd1);
        check("t4_width_count", 32'(widths.size()), 32'd1);
        check_widths("t4_width");
        check("t4_busy", {31'd0, busy}, 32'd0);
        check("t4_pos", pos, 32'hFFFF_FFFC);

        // 5: asynchronous reset mid-HIGH, then restart
        en = 1'b1;
        repeat (2) tick();
        #2 reset = 1'b1;
        #1;
        check("t5_async_step_out", {31'd0, step_out}, 32'd0);
        check("t5_async_dir_out",  {31'd0, dir_out},  32'd0);
        check("t5_async_busy",     {31'd0, busy},     32'd0);
        check("t5_async_pos",      pos,               32'd0);
        tick();
        clear_log();
        reset = 1'b0;
        repeat (10) tick();
        check("t5_restart_rises", 32'(rises.size()), 32'd1);
        check("t5_restart_pos", pos, 32'd1);
        check("t5_restart_busy", {31'd0, busy}, 32'd1);
        en = 1'b0;
        repeat (20) tick();

        // 6: clr_pos coinciding with HIGH entry wins
        clear_log();
        en = 1'b1; speed = 32'd20; direction = 1'b1; clr_pos = 1'b1;
        tick();
        clr_pos = 1'b0;
        check("t6_clr_pos", pos, 32'd0);
        check("t6_clr_step_out", {31'd0, step_out}, 32'd1);
        repeat (21) tick();
        check("t6_next_pos", pos, 32'd1);
        check("t6_rise_count", 32'(rises.size()), 32'd2);
        en = 1'b0;
        repeat (8) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
